sram64_mem_ctrl: RTL and testbench

//  Sequences the 64-bit-read / 32-bit-write asynchronous SRAM for the MEM stage of the ARM pipeline.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram64_line_buf.sv | 40 ++++
 rtl/sram64_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_sram64_mem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM64 MEM-stage controller: bus widths, FSM states,
// and the byte-address to SRAM-word-address mapping.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW       = 17;
  localparam int unsigned SRAM_DW       = 64;
  localparam int unsigned TAG_W         = SRAM_AW - 1;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Byte offset from the base, dropped to word granularity; wraps silently mod 2^17.
  function automatic logic [SRAM_AW-1:0] byte_to_waddr(input logic [31:0] addr,
                                                        input logic [31:0] base);
    return SRAM_AW'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram64_line_buf.sv
// One-entry 64-bit line buffer: holds the last SRAM line read, tagged by the word
// address with its half-select bit dropped.
module sram64_line_buf
  import sram_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [TAG_W-1:0]   lookup_tag_i,
  output logic               hit_o,
  output logic [SRAM_DW-1:0] data_o,
  input  logic               fill_en_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [SRAM_DW-1:0] fill_data_i,
  input  logic               inv_en_i,
  input  logic [TAG_W-1:0]   inv_tag_i
);

  logic               valid_q;
  logic [TAG_W-1:0]   tag_q;
  logic [SRAM_DW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (inv_en_i && valid_q && (inv_tag_i == tag_q)) begin
      // Any write into the buffered line makes the copy stale, whichever half it hits.
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (lookup_tag_i == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/sram64_mem_ctrl.sv
// MEM-stage sequencer for the 64-bit-read / 32-bit-write asynchronous SRAM.
// Define SRAM_LINE_BUF_EN to add a one-line read buffer that short-circuits repeat reads.
module sram64_mem_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ADDR,
  input  logic [31:0]        WR_DATA,
  output logic [31:0]        RD_DATA,
  output logic               READY,
  output logic               SRAM_WE_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output state_e             dbg_state_o
);

  localparam int unsigned   CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               op_wr_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               we_n_q;
  logic               dq_oe_q;
  logic [31:0]        rd_data_q;

  logic [SRAM_AW-1:0] req_waddr;
  logic               req;
  logic               last_beat;
  logic               lb_take;
  logic [31:0]        lb_word;

  assign req_waddr = byte_to_waddr(ADDR, BASE_ADDR);
  assign req       = MEM_R_EN | MEM_W_EN;
  assign last_beat = (cnt_q == CNT_LAST);

`ifdef SRAM_LINE_BUF_EN
  logic               lb_hit;
  logic [SRAM_DW-1:0] lb_data;

  sram64_line_buf u_line_buf (
    .clk_i        (CLK),
    .rst_i        (RST),
    .lookup_tag_i (req_waddr[SRAM_AW-1:1]),
    .hit_o        (lb_hit),
    .data_o       (lb_data),
    .fill_en_i    ((state_q == ST_ACCESS) && last_beat && !op_wr_q),
    .fill_tag_i   (addr_q[SRAM_AW-1:1]),
    .fill_data_i  (SRAM_DQ),
    .inv_en_i     ((state_q == ST_IDLE) && MEM_W_EN),
    .inv_tag_i    (req_waddr[SRAM_AW-1:1])
  );

  always_comb begin
    lb_take = (state_q == ST_IDLE) && MEM_R_EN && !MEM_W_EN && lb_hit;
    lb_word = req_waddr[0] ? lb_data[63:32] : lb_data[31:0];
  end
`else
  always_comb begin
    lb_take = 1'b0;
    lb_word = '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lb_take) begin
            rd_data_q <= lb_word;
            state_q   <= ST_DONE;
          end else if (req) begin
            // Write wins when both enables are raised together.
            op_wr_q <= MEM_W_EN;
            addr_q  <= req_waddr;
            wdata_q <= WR_DATA;
            we_n_q  <= !MEM_W_EN;
            dq_oe_q <= MEM_W_EN;
            cnt_q   <= '0;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (last_beat) begin
            // WE_N rises on the same edge DQ is released, so the bus never fights.
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_DONE;
            if (!op_wr_q) begin
              rd_data_q <= addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign READY       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign RD_DATA     = rd_data_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ     = dq_oe_q ? {32'b0, wdata_q} : {SRAM_DW{1'bz}};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram64_mem_ctrl.sv
// Bench for sram64_mem_ctrl: SRAM64 pin model, per-cycle expectation queue built from
// the access timeline, directed cases followed by random traffic.
`timescale 1ns/1ps
module tb_sram64_mem_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned W    = 3;
  localparam logic [31:0] BASE = 32'd1024;
  localparam logic [63:0] REL  = {64{1'b1}};  // released bus reads as the pull-up value

  logic        clk = 1'b0;
  logic        rst, r_en, w_en;
  logic [31:0] addr, wdata;
  wire  [31:0] rd_data;
  wire         ready, we_n;
  wire  [16:0] sram_addr;
  wire  [63:0] sram_dq;
  state_e      dbg_state;

  sram64_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .CLK(clk), .RST(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ADDR(addr), .WR_DATA(wdata),
    .RD_DATA(rd_data), .READY(ready), .SRAM_WE_N(we_n), .SRAM_ADDR(sram_addr),
    .SRAM_DQ(sram_dq), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  // ---------------- SRAM64 pin model ----------------
  logic [31:0] sram_mem [int];
  logic [31:0] ref_mem  [int];
  logic [63:0] sram_rd = '0;
  logic        rd_phase = 1'b0;

  pullup pu_dq (sram_dq);
  assign sram_dq = (rd_phase && we_n) ? sram_rd : 64'bz;

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h0100_0193) ^ 32'hA5A5_5A5A;
  endfunction
  function automatic logic [31:0] sram_word(input int unsigned a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_word(input int unsigned a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  always @(negedge clk) begin
    if (!we_n) sram_mem[int'(sram_addr)] = sram_dq[31:0];
  end
  always @(negedge clk) begin
    sram_rd = {sram_word(int'({sram_addr[16:1], 1'b1})), sram_word(int'({sram_addr[16:1], 1'b0}))};
  end

  // ---------------- reference model state ----------------
  logic [31:0] last_rd;
  bit          lb_valid;
  int unsigned lb_tag;
  logic [16:0] last_acc_addr = '0;

  function automatic int unsigned waddr_of(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return (off / 4) % 131072;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          ready;
    bit          we_n;
    bit          chk_addr;
    logic [16:0] addr;
    bit          chk_dq;
    logic [63:0] dq;
    logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input bit rdy, input bit wen, input bit ca, input logic [16:0] a,
                              input bit cd, input logic [63:0] dq);
    exp_t e;
    e.ready = rdy; e.we_n = wen; e.chk_addr = ca; e.addr = a;
    e.chk_dq = cd; e.dq = dq; e.rd = last_rd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ready", 64'(ready), 64'(e.ready));
      chk("we_n", 64'(we_n), 64'(e.we_n));
      chk("rd_data", 64'(rd_data), 64'(e.rd));
      if (e.chk_addr) begin
        chk("sram_addr", 64'(sram_addr), 64'(e.addr));
        last_acc_addr = sram_addr;
      end
      if (e.chk_dq) chk("sram_dq", sram_dq, e.dq);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r_en = 1'b0; w_en = 1'b0; rd_phase = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, '0, 1'b1, REL));
    step();
  endtask

  task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    int unsigned wa;
    bit          hit;
    wa  = waddr_of(a);
    hit = 1'b0;
`ifdef SRAM_LINE_BUF_EN
    hit = !wr && lb_valid && (lb_tag == wa / 2);
`endif
    r_en = rd; w_en = wr; addr = a; wdata = d; rd_phase = !wr;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, wr, REL));
    if (hit) begin
      last_rd = ref_word(wa);
      step();
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, '0, 1'b0, '0));
      step();
      return;
    end
    for (int i = 0; i < W; i++) begin
      step();
      exp_q.push_back(mk(1'b0, !wr, 1'b1, 17'(wa), wr, {32'b0, d}));
    end
    if (wr) begin
      ref_mem[int'(wa)] = d;
      if (lb_valid && lb_tag == wa / 2) lb_valid = 1'b0;
    end else begin
      last_rd  = ref_word(wa);
      lb_valid = 1'b1;
      lb_tag   = wa / 2;
    end
    step();
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, '0, wr, REL));
    step();
  endtask

  // Write aborted by reset during its second ACCESS cycle; the target word is never read back.
  task automatic wr_reset(input logic [31:0] a, input logic [31:0] d);
    int unsigned wa;
    wa = waddr_of(a);
    r_en = 1'b0; w_en = 1'b1; addr = a; wdata = d; rd_phase = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, 1'b1, REL));
    step();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 17'(wa), 1'b1, {32'b0, d}));
    step();
    rst = 1'b1; w_en = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 17'(wa), 1'b1, {32'b0, d}));
    step();
    rst = 1'b0;
    last_rd  = '0;
    lb_valid = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 17'd0, 1'b1, REL));
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; addr = '0; wdata = '0;
    last_rd = '0; lb_valid = 1'b0; lb_tag = 0;

    step();
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 17'd0, 1'b1, REL));
    step();
    rst = 1'b0;
    idle();

    do_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    chk("mem1_after_write", 64'(sram_word(1)), 64'h0000_0000_DEAD_BEEF);
    chk("write_word_addr", 64'(last_acc_addr), 64'd1);
    idle(); idle();

    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("read_1028", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);
    do_op(1'b0, 1'b1, 32'd1024, 32'h0);
    chk("read_1024", 64'(rd_data), 64'(init_word(0)));

    do_op(1'b1, 1'b1, 32'd1032, 32'd5);
    chk("mem2_rw_both", 64'(sram_word(2)), 64'd5);
    chk("rd_hold_after_write", 64'(rd_data), 64'(init_word(0)));

    do_op(1'b0, 1'b1, 32'd0, 32'h0);
    chk("wrap_word_addr", 64'(last_acc_addr), 64'h1_FF00);

    wr_reset(BASE + 32'd2000, 32'hCAFE_F00D);
    idle();

`ifdef SRAM_LINE_BUF_EN
    do_op(1'b0, 1'b1, 32'd1024, 32'h0);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("lb_hit_data", 64'(rd_data), 64'h0000_0000_DEAD_BEEF);
    do_op(1'b1, 1'b0, 32'd1028, 32'h1234_5678);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("lb_after_inval", 64'(rd_data), 64'h0000_0000_1234_5678);
    idle();
`endif

    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 255) * 4;
      else                           a = BASE + $urandom_range(0, 15) * 4;
      if (sel < 4)       do_op(1'b0, 1'b1, a, 32'h0);
      else if (sel < 8)  do_op(1'b1, 1'b0, a, $urandom);
      else if (sel == 8) do_op(1'b1, 1'b1, a, $urandom);
      else               idle();
    end

    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
